// File: rtl/lfsr_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// lfsr_vga_pattern_gen
//
// LFSR-driven VGA test-pattern source. It produces sync timing from a
// divided pixel tick and fills the visible area with one of four patterns:
// per-pixel noise, per-cell (block) noise, eight colour bars, or black.
// The noise generator can be reseeded at runtime. It can also be frozen so
// that every frame repeats the same image. This is used to bring up the
// display path and to seed the lifegame board.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   mode         0 pixel noise, 1 cell noise, 2 colour bars, 3 black
//                (sampled once per frame, at pixel (0,0))
//   freeze       1 = restart every frame from the same LFSR state
//   seed         seed value, captured while seed_load is high
//   seed_load    one-clk request; the seed is applied at the next frame start
//   vgaRed       5-bit red   (all ones or zero)
//   vgaGreen     6-bit green (all ones or zero)
//   vgaBlue      5-bit blue  (all ones or zero)
//   hsync/vsync  sync outputs, asserted level = SYNC_POL
//   active       pixel data valid, aligned with RGB
//   frame_start  one-clk pulse together with the output of pixel (0,0)
//
// All outputs are registered on the pixel tick that follows the counter
// value producing them, so syncs, active and RGB share one pixel of delay.
// ---------------------------------------------------------------------------
module lfsr_vga_pattern_gen #(
    parameter int                PIX_DIV   = 4,
    parameter int                H_ACTIVE  = 800,
    parameter int                H_FP      = 40,
    parameter int                H_SYNC    = 128,
    parameter int                H_BP      = 88,
    parameter int                V_ACTIVE  = 600,
    parameter int                V_FP      = 1,
    parameter int                V_SYNC    = 4,
    parameter int                V_BP      = 23,
    parameter logic              SYNC_POL  = 1'b1,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter int                CELL_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              freeze,
    input  logic [LFSR_W-1:0] seed,
    input  logic              seed_load,
    output logic [4:0]        vgaRed,
    output logic [5:0]        vgaGreen,
    output logic [4:0]        vgaBlue,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              frame_start
);

    typedef enum logic [1:0] {
        MODE_PIXEL = 2'd0,
        MODE_CELL  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_BLACK = 2'd3
    } mode_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One extra count of headroom so the sync-end bounds fit the counters
    // even when a back porch is zero.
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int CELL    = 1 << CELL_LOG2;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PIX_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT      = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]   V_ACT      = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0]   H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]   V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [H_W-1:0]   CELL_MASK_H = H_W'(CELL - 1);
    localparam logic [V_W-1:0]   CELL_MASK_V = V_W'(CELL - 1);

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    // State
    logic [DIV_W-1:0]  div_cnt;
    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] frame_save;
    logic [LFSR_W-1:0] row_save;
    logic [LFSR_W-1:0] seed_q;
    logic              seed_pending;
    mode_t             mode_q;

    // Decode of the current counter position
    logic              tick;
    logic              at_origin;
    logic              in_active;
    logic              in_hsync;
    logic              in_vsync;
    mode_t             mode_eff;
    logic [LFSR_W-1:0] seed_fixed;
    logic [LFSR_W-1:0] lfsr_frame;
    logic [LFSR_W-1:0] lfsr_cur;
    logic [LFSR_W-1:0] lfsr_next;
    logic              row_start;
    logic              row_first;
    logic              cell_end;
    logic              step_en;
    logic [2:0]        bar_idx;
    logic              r_on;
    logic              g_on;
    logic              b_on;

    // NOTE: every signal gets a default at the top of the block, so no path
    // through the case/if logic can leave one unassigned and infer a latch.
    always_comb begin
        tick       = (div_cnt == DIV_LAST);
        at_origin  = (h_cnt == '0) && (v_cnt == '0);
        in_active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_hsync   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        in_vsync   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

        // Pixel (0,0) already uses the newly latched mode and the
        // frame-start LFSR choice, so a whole frame is drawn consistently.
        mode_eff   = at_origin ? mode_t'(mode) : mode_q;
        seed_fixed = (seed_q == '0) ? LFSR_W'(1) : seed_q;

        lfsr_frame = lfsr;
        if (at_origin) begin
            if (seed_pending)
                lfsr_frame = seed_fixed;
            else if (freeze)
                lfsr_frame = frame_save;
        end

        // Cell mode: the first line of a cell row records its starting
        // state and the remaining lines replay it, so each cell is uniform
        // vertically as well as horizontally.
        row_start = (mode_eff == MODE_CELL) && in_active && (h_cnt == '0);
        row_first = (v_cnt & CELL_MASK_V) == '0;
        lfsr_cur  = (row_start && !row_first) ? row_save : lfsr_frame;

        cell_end  = (h_cnt & CELL_MASK_H) == CELL_MASK_H;
        step_en   = in_active &&
                    ((mode_eff == MODE_PIXEL) || ((mode_eff == MODE_CELL) && cell_end));
        lfsr_next = step_en ? lfsr_step(lfsr_cur) : lfsr_cur;

        bar_idx   = 3'((32'(h_cnt) * 32'd8) / H_ACTIVE);

        r_on = 1'b0;
        g_on = 1'b0;
        b_on = 1'b0;
        case (mode_eff)
            MODE_PIXEL, MODE_CELL: begin
                r_on = lfsr_cur[0];
                g_on = lfsr_cur[0];
                b_on = lfsr_cur[0];
            end
            MODE_BARS: begin
                r_on = bar_idx[2];
                g_on = bar_idx[1];
                b_on = bar_idx[0];
            end
            default: ;
        endcase
        r_on = r_on && in_active;
        g_on = g_on && in_active;
        b_on = b_on && in_active;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and they all update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt      <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            lfsr         <= LFSR_W'(1);
            frame_save   <= LFSR_W'(1);
            row_save     <= LFSR_W'(1);
            seed_q       <= '0;
            seed_pending <= 1'b0;
            mode_q       <= MODE_PIXEL;
            vgaRed       <= '0;
            vgaGreen     <= '0;
            vgaBlue      <= '0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            active       <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
            frame_start <= tick && at_origin;

            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
                end else begin
                    h_cnt <= h_cnt + H_W'(1);
                end

                lfsr <= lfsr_next;
                if (row_start && row_first)
                    row_save <= lfsr_cur;

                if (at_origin) begin
                    mode_q <= mode_t'(mode);
                    if (seed_pending)
                        frame_save <= seed_fixed;
                    else if (!freeze)
                        frame_save <= lfsr;
                end

                vgaRed   <= {5{r_on}};
                vgaGreen <= {6{g_on}};
                vgaBlue  <= {5{b_on}};
                hsync    <= in_hsync ? SYNC_POL : ~SYNC_POL;
                vsync    <= in_vsync ? SYNC_POL : ~SYNC_POL;
                active   <= in_active;
            end

            // A load always wins over the frame-start clear, so a request on
            // the frame-start clk stays pending for the following frame.
            if (seed_load) begin
                seed_pending <= 1'b1;
                seed_q       <= seed;
            end else if (tick && at_origin) begin
                seed_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_vga_pattern_gen
//
// Bench for lfsr_vga_pattern_gen on a reduced raster (40x20 pixel ticks,
// 32x16 visible, 8x8 cells, two clks per pixel). A frame-level model builds
// each frame's image from the LFSR state chosen at frame start. A compare
// process checks every clk against it. Directed checks pin the model with
// hand-computed pixels, sync edges and bar colours.
// ---------------------------------------------------------------------------
module tb_lfsr_vga_pattern_gen;

    localparam int PD   = 2;
    localparam int HA   = 32;
    localparam int HFP  = 2;
    localparam int HS   = 4;
    localparam int HBP  = 2;
    localparam int VA   = 16;
    localparam int VFP  = 1;
    localparam int VS   = 2;
    localparam int VBP  = 1;
    localparam int CL   = 3;
    localparam int HT   = HA + HFP + HS + HBP;
    localparam int VT   = VA + VFP + VS + VBP;
    localparam int FT   = HT * VT;
    localparam int CELL = 1 << CL;
    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLACK = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        freeze = 1'b0;
    logic [15:0] seed = 16'h0;
    logic        seed_load = 1'b0;
    logic [4:0]  vgaRed;
    logic [5:0]  vgaGreen;
    logic [4:0]  vgaBlue;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic        frame_start;

    always #5 clk = ~clk;

    lfsr_vga_pattern_gen #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b1), .LFSR_W(16), .LFSR_TAPS(16'hB400), .CELL_LOG2(CL)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .freeze(freeze), .seed(seed),
        .seed_load(seed_load), .vgaRed(vgaRed), .vgaGreen(vgaGreen),
        .vgaBlue(vgaBlue), .hsync(hsync), .vsync(vsync), .active(active),
        .frame_start(frame_start)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [15:0] m_lfsr;
    logic [15:0] m_fsave;
    logic [15:0] m_seed;
    bit          m_pend;
    int          m_mode;
    bit          m_live [VA][HA];
    int          edge_n = 0;
    int          fcount = 0;
    int          cur_f  = -1;
    logic [31:0] sig [32];
    logic [15:0] cell_img [VA][HA];

    function automatic logic [15:0] step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
    endfunction

    // Noise frames consume one LFSR value per pixel in raster order; cell
    // frames consume one value per cell, row of cells by row of cells.
    task build_frame();
        if (m_mode == 0) begin
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++) begin
                    m_live[y][x] = m_lfsr[0];
                    m_lfsr = step(m_lfsr);
                end
        end else if (m_mode == 1) begin
            for (int cy = 0; cy < VA / CELL; cy++)
                for (int cx = 0; cx < HA / CELL; cx++) begin
                    for (int y = 0; y < CELL; y++)
                        for (int x = 0; x < CELL; x++)
                            m_live[cy*CELL + y][cx*CELL + x] = m_lfsr[0];
                    m_lfsr = step(m_lfsr);
                end
        end
    endtask

    function automatic logic [15:0] model_colour(input int h, input int v);
        int idx;
        case (m_mode)
            0, 1: return m_live[v][h] ? WHITE : BLACK;
            2: begin
                idx = h * 8 / HA;
                return {{5{idx[2]}}, {6{idx[1]}}, {5{idx[0]}}};
            end
            default: return BLACK;
        endcase
    endfunction

    // Compare process: one combined comparison of all outputs every clk.
    initial begin
        logic        rs, fz, sl;
        logic [1:0]  ms;
        logic [15:0] sd, col;
        logic [19:0] want;
        int          p, h, v;
        bit          tk, act, hs_e, vs_e, fs_e;
        forever begin
            @(posedge clk);
            rs = rst; ms = mode; fz = freeze; sd = seed; sl = seed_load;
            #1;
            want = '0;
            if (!rs) begin
                edge_n  = 0;
                m_lfsr  = 16'h1;
                m_fsave = 16'h1;
                m_pend  = 1'b0;
                m_mode  = 0;
            end else begin
                edge_n++;
                if (edge_n >= PD) begin
                    p  = edge_n / PD - 1;
                    h  = p % HT;
                    v  = (p / HT) % VT;
                    tk = (edge_n % PD) == 0;
                    if (tk && (p % FT) == 0) begin
                        if (m_pend) begin
                            m_lfsr  = (m_seed == 16'h0) ? 16'h1 : m_seed;
                            m_fsave = m_lfsr;
                            m_pend  = 1'b0;
                        end else if (fz) begin
                            m_lfsr = m_fsave;
                        end else begin
                            m_fsave = m_lfsr;
                        end
                        m_mode = int'(ms);
                        build_frame();
                        fcount++;
                        cur_f = fcount - 1;
                        if (cur_f < 32) sig[cur_f] = 32'h0;
                    end
                    act  = (h < HA) && (v < VA);
                    hs_e = (h >= HA + HFP) && (h < HA + HFP + HS);
                    vs_e = (v >= VA + VFP) && (v < VA + VFP + VS);
                    fs_e = tk && (h == 0) && (v == 0);
                    col  = act ? model_colour(h, v) : BLACK;
                    want = {col, hs_e, vs_e, act, fs_e};
                    if (tk && act && cur_f >= 0 && cur_f < 32) begin
                        sig[cur_f] = sig[cur_f] * 32'd31 + {16'h0, vgaRed, vgaGreen, vgaBlue} + 32'd1;
                        if (cur_f == 4) cell_img[v][h] = {vgaRed, vgaGreen, vgaBlue};
                    end
                end
                if (sl) begin
                    m_pend = 1'b1;
                    m_seed = sd;
                end
            end
            check("cycle", {12'h0, vgaRed, vgaGreen, vgaBlue, hsync, vsync, active, frame_start},
                  {12'h0, want});
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic int pix_edge(input int f, input int h, input int v);
        return ((f * FT + v * HT + h) + 1) * PD;
    endfunction

    task automatic wait_edge(input int target);
        int guard = 0;
        while (edge_n < target && guard < 40000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (edge_n != target) begin
            errors++;
            $display("FAIL wait_edge reached %0d expected %0d", edge_n, target);
        end
    endtask

    task automatic chk_pix(input string name, input int f, input int h, input int v,
                           input logic [15:0] want);
        wait_edge(pix_edge(f, h, v));
        check(name, {16'h0, vgaRed, vgaGreen, vgaBlue}, {16'h0, want});
    endtask

    task automatic pulse_load(input logic [15:0] value);
        seed      = value;
        seed_load = 1'b1;
        @(posedge clk);
        #2;
        seed_load = 1'b0;
    endtask

    initial begin
        int bad, changes;

        // Reset held for 20 clks
        repeat (20) @(posedge clk);
        #2;
        check("rst_rgb", {16'h0, vgaRed, vgaGreen, vgaBlue}, 32'h0);
        check("rst_sync", {30'h0, hsync, vsync}, 32'h0);
        check("rst_active", {31'h0, active}, 32'h0);
        check("rst_frame_start", {31'h0, frame_start}, 32'h0);
        rst = 1'b1;

        // Frame 0: first tick, noise from L=1
        wait_edge(PD - 1);
        check("fs_early", {31'h0, frame_start}, 32'h0);
        wait_edge(PD);
        check("fs_first", {31'h0, frame_start}, 32'h1);
        check("f0_p0", {16'h0, vgaRed, vgaGreen, vgaBlue}, {16'h0, WHITE});
        chk_pix("f0_p1", 0, 1, 0, BLACK);
        chk_pix("f0_p11", 0, 11, 0, WHITE);
        wait_edge(pix_edge(0, 31, 0));
        check("active_last", {31'h0, active}, 32'h1);
        wait_edge(pix_edge(0, 32, 0));
        check("active_off", {31'h0, active}, 32'h0);
        wait_edge(pix_edge(0, 33, 0));
        check("hsync_before", {31'h0, hsync}, 32'h0);
        wait_edge(pix_edge(0, 34, 0));
        check("hsync_start", {31'h0, hsync}, 32'h1);
        wait_edge(pix_edge(0, 38, 0));
        check("hsync_end", {31'h0, hsync}, 32'h0);
        wait_edge(pix_edge(0, 0, 16));
        check("vsync_before", {31'h0, vsync}, 32'h0);
        wait_edge(pix_edge(0, 0, 17));
        check("vsync_start", {31'h0, vsync}, 32'h1);
        wait_edge(pix_edge(0, 0, 19));
        check("vsync_end", {31'h0, vsync}, 32'h0);

        // Freeze for frames 2 and 3
        wait_edge(pix_edge(1, 0, 5));
        freeze = 1'b1;

        // Frame 4: cell mode seeded with ACE1
        wait_edge(pix_edge(3, 0, 5));
        freeze = 1'b0;
        mode   = 2'd1;
        pulse_load(16'hACE1);
        chk_pix("cell_00", 4, 0, 0, WHITE);
        chk_pix("cell_80", 4, 8, 0, BLACK);
        chk_pix("cell_35", 4, 3, 5, WHITE);
        chk_pix("cell_08", 4, 0, 8, BLACK);
        chk_pix("cell_89", 4, 8, 9, WHITE);
        wait_edge(pix_edge(4, 0, 10));
        mode = 2'd0;

        wait_edge(pix_edge(5, 0, 0));
        bad = 0;
        changes = 0;
        for (int by = 0; by < VA / CELL; by++)
            for (int bx = 0; bx < HA / CELL; bx++)
                for (int y = 0; y < CELL; y++)
                    for (int x = 0; x < CELL; x++)
                        if (cell_img[by*CELL + y][bx*CELL + x] != cell_img[by*CELL][bx*CELL])
                            bad++;
        for (int k = 1; k < HA / CELL; k++)
            if (cell_img[0][k*CELL] != cell_img[0][k*CELL - 1]) changes++;
        check("cell_uniform", bad, 0);
        check("cell_row0_edges", changes, 1);

        // Mid-frame switch to bars: frame 5 stays noise, frame 6 shows bars
        wait_edge(pix_edge(5, 0, 5));
        mode = 2'd2;
        chk_pix("bar0", 6, 0, 0, BLACK);
        chk_pix("bar1_blue", 6, 4, 0, 16'h001F);
        chk_pix("bar2_green", 6, 8, 0, 16'h07E0);
        chk_pix("bar4_red", 6, 16, 2, 16'hF800);
        chk_pix("bar7", 6, 31, 5, WHITE);

        // Seed 0 maps to 1
        wait_edge(pix_edge(6, 0, 8));
        mode = 2'd0;
        pulse_load(16'h0000);
        chk_pix("seed0_p0", 7, 0, 0, WHITE);
        chk_pix("seed0_p1", 7, 1, 0, BLACK);
        chk_pix("seed0_p11", 7, 11, 0, WHITE);

        // Later load overwrites an earlier one
        wait_edge(pix_edge(7, 0, 8));
        pulse_load(16'h1234);
        wait_edge(pix_edge(7, 0, 9));
        pulse_load(16'hACE1);
        chk_pix("ace1_p0", 8, 0, 0, WHITE);
        chk_pix("ace1_p1", 8, 1, 0, BLACK);
        chk_pix("ace1_p5", 8, 5, 0, WHITE);
        wait_edge(pix_edge(8, 0, 8));
        pulse_load(16'hACE1);

        // Load on the frame-start clk of frame 10 is deferred to frame 11
        wait_edge(pix_edge(10, 0, 0) - 1);
        seed_load = 1'b1;
        @(posedge clk);
        #2;
        seed_load = 1'b0;

        wait_edge(pix_edge(11, 0, 0));
        check("free_run_differs", {31'h0, sig[1] != sig[0]}, 32'h1);
        check("freeze_repeat", sig[3], sig[2]);
        check("seed_repeat", sig[9], sig[8]);
        check("deferred_load", {31'h0, sig[10] != sig[9]}, 32'h1);
        check("deferred_p0", {16'h0, vgaRed, vgaGreen, vgaBlue}, {16'h0, WHITE});
        chk_pix("deferred_p1", 11, 1, 0, BLACK);
        chk_pix("deferred_p5", 11, 5, 0, WHITE);

        // Reset in the middle of a sync pulse
        wait_edge(pix_edge(11, 35, 3));
        check("pre_reset_hsync", {31'h0, hsync}, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_outputs",
              {12'h0, vgaRed, vgaGreen, vgaBlue, hsync, vsync, active, frame_start}, 32'h0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        wait_edge(PD);
        check("restart_fs", {31'h0, frame_start}, 32'h1);
        check("restart_p0", {16'h0, vgaRed, vgaGreen, vgaBlue}, {16'h0, WHITE});
        chk_pix("restart_p11", 0, 11, 0, WHITE);
        wait_edge(pix_edge(0, 0, 10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
